// File: rtl/iomem_initiator.sv
// iomem_initiator: bus-master end of the iomem valid/ready peripheral bus.
// Takes one read/write command at a time, runs one iomem transaction for it,
// and returns the read data or an error on the response port. A watchdog
// aborts bus cycles that the responder never completes.
module iomem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    // Watchdog is 16 bits so the full 1..65535 timeout range fits.
    localparam logic [15:0] WDOG_LOAD = 16'(TIMEOUT_CYCLES);

    state_t      r_state,       w_state_nxt;
    logic [15:0] r_wdog,        w_wdog_nxt;
    logic        r_cmd_ready,   w_cmd_ready_nxt;
    logic        r_rsp_valid,   w_rsp_valid_nxt;
    logic [31:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic        r_rsp_error,   w_rsp_error_nxt;
    logic        r_busy,        w_busy_nxt;
    logic        r_iomem_valid, w_iomem_valid_nxt;
    logic [3:0]  r_iomem_wstrb, w_iomem_wstrb_nxt;
    logic [31:0] r_iomem_addr,  w_iomem_addr_nxt;
    logic [31:0] r_iomem_wdata, w_iomem_wdata_nxt;

    logic w_cmd_fire;
    logic w_cmd_reject;

    assign w_cmd_fire   = cmd_valid && r_cmd_ready;
    // A write with no byte enables would look like a read on the bus.
    assign w_cmd_reject = cmd_write && (cmd_wstrb == 4'b0000);

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        // NOTE: every target gets a default first (hold current value) so no
        // path through the case leaves it unassigned and infers a latch.
        w_state_nxt       = r_state;
        w_wdog_nxt        = r_wdog;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_error_nxt   = r_rsp_error;
        w_iomem_valid_nxt = r_iomem_valid;
        w_iomem_wstrb_nxt = r_iomem_wstrb;
        w_iomem_addr_nxt  = r_iomem_addr;
        w_iomem_wdata_nxt = r_iomem_wdata;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (w_cmd_fire) begin
                    w_cmd_ready_nxt = 1'b0;
                    if (w_cmd_reject) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_error_nxt = 1'b1;
                        w_rsp_rdata_nxt = ERR_RDATA;
                    end else begin
                        w_state_nxt       = S_BUS;
                        w_iomem_valid_nxt = 1'b1;
                        w_iomem_addr_nxt  = {cmd_addr[31:2], 2'b00};
                        w_iomem_wdata_nxt = cmd_wdata;
                        w_iomem_wstrb_nxt = cmd_write ? cmd_wstrb : 4'b0000;
                        w_wdog_nxt        = WDOG_LOAD;
                    end
                end
            end

            S_BUS: begin
                // Completion has priority over a watchdog expiry on the same edge.
                if (iomem_ready) begin
                    w_state_nxt       = S_RESP;
                    w_iomem_valid_nxt = 1'b0;
                    w_iomem_wstrb_nxt = 4'b0000;
                    w_rsp_rdata_nxt   = (r_iomem_wstrb == 4'b0000) ? iomem_rdata : 32'h0;
                    w_rsp_error_nxt   = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                end else if (r_wdog <= 16'd1) begin
                    w_state_nxt       = S_RESP;
                    w_wdog_nxt        = 16'd0;
                    w_iomem_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt   = ERR_RDATA;
                    w_rsp_error_nxt   = 1'b1;
                    w_rsp_valid_nxt   = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog - 16'd1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state       <= S_IDLE;
            r_wdog        <= 16'd0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_error   <= 1'b0;
            r_busy        <= 1'b0;
            r_iomem_valid <= 1'b0;
            r_iomem_wstrb <= 4'b0000;
            r_iomem_addr  <= 32'h0;
            r_iomem_wdata <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_wdog        <= w_wdog_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_error   <= w_rsp_error_nxt;
            r_busy        <= w_busy_nxt;
            r_iomem_valid <= w_iomem_valid_nxt;
            r_iomem_wstrb <= w_iomem_wstrb_nxt;
            r_iomem_addr  <= w_iomem_addr_nxt;
            r_iomem_wdata <= w_iomem_wdata_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign busy        = r_busy;
    assign iomem_valid = r_iomem_valid;
    assign iomem_wstrb = r_iomem_wstrb;
    assign iomem_addr  = r_iomem_addr;
    assign iomem_wdata = r_iomem_wdata;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed testbench for iomem_initiator with a behavioural GPIO responder.
module tb_iomem_initiator;

    localparam logic [31:0] GPIO_ADDR = 32'h0300_0000;
    localparam logic [31:0] ERR       = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_error, busy;
    logic [31:0] rsp_rdata;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata;
    logic [31:0] iomem_rdata = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder model state
    logic        resp_en = 1'b1;
    logic        seen = 1'b0;
    logic [31:0] gpio_reg = 32'h0000_0003;
    int          valid_cycles = 0;
    int          late_req_cnt = 0;
    int          late_done_cnt = 0;

    iomem_initiator #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
    );

    always #5 clk = ~clk;

    // Zero-wait GPIO responder: ready is seen by the initiator two edges after accept.
    always @(negedge clk) begin
        if (iomem_valid) valid_cycles++;
        if (iomem_ready) begin
            iomem_ready = 1'b0;
        end else if (late_req_cnt != late_done_cnt) begin
            iomem_ready = 1'b1;
            late_done_cnt++;
        end else if (!iomem_valid) begin
            seen = 1'b0;
        end else if (resp_en && iomem_addr == GPIO_ADDR) begin
            if (!seen) begin
                seen = 1'b1;
            end else begin
                seen = 1'b0;
                iomem_ready = 1'b1;
                iomem_rdata = gpio_reg;
                for (int b = 0; b < 4; b++)
                    if (iomem_wstrb[b]) gpio_reg[b*8 +: 8] = iomem_wdata[b*8 +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) cyc = -1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        repeat (3) tick();
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_error !== 1'b0) $display("FAIL rst_rsp_error: got %b exp 0", rsp_error); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata: got %h exp 0", rsp_rdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (iomem_valid !== 1'b0) $display("FAIL rst_iomem_valid: got %b exp 0", iomem_valid); else n_pass++;
        n_checks++; if (iomem_wstrb !== 4'h0) $display("FAIL rst_iomem_wstrb: got %h exp 0", iomem_wstrb); else n_pass++;
        n_checks++; if (iomem_addr !== 32'h0) $display("FAIL rst_iomem_addr: got %h exp 0", iomem_addr); else n_pass++;
        n_checks++; if (iomem_wdata !== 32'h0) $display("FAIL rst_iomem_wdata: got %h exp 0", iomem_wdata); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_exit_cmd_ready: got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_exit_busy: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_read();
        issue(1'b0, GPIO_ADDR, 32'h0, 4'h0);
        n_checks++; if (iomem_valid !== 1'b1) $display("FAIL rd_valid_n: got %b exp 1", iomem_valid); else n_pass++;
        n_checks++; if (iomem_wstrb !== 4'h0) $display("FAIL rd_wstrb: got %h exp 0", iomem_wstrb); else n_pass++;
        n_checks++; if (iomem_addr !== GPIO_ADDR) $display("FAIL rd_addr: got %h exp %h", iomem_addr, GPIO_ADDR); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rd_cmd_ready: got %b exp 0", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b exp 1", busy); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_early: got %b exp 0", rsp_valid); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_n2: got %b exp 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h3) $display("FAIL rd_rdata: got %h exp 00000003", rsp_rdata); else n_pass++;
        n_checks++; if (rsp_error !== 1'b0) $display("FAIL rd_error: got %b exp 0", rsp_error); else n_pass++;
        n_checks++; if (iomem_valid !== 1'b0) $display("FAIL rd_valid_drop: got %b exp 0", iomem_valid); else n_pass++;
        consume();
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL rd_done: got rsp_valid=%b cmd_ready=%b exp 0/1", rsp_valid, cmd_ready); else n_pass++;
    endtask

    task automatic test_write();
        int cyc;
        issue(1'b1, 32'h0300_0002, 32'h1234_ABCD, 4'b0011);
        n_checks++; if (iomem_addr !== GPIO_ADDR) $display("FAIL wr_addr_align: got %h exp %h", iomem_addr, GPIO_ADDR); else n_pass++;
        n_checks++; if (iomem_wstrb !== 4'b0011) $display("FAIL wr_wstrb: got %b exp 0011", iomem_wstrb); else n_pass++;
        n_checks++; if (iomem_wdata !== 32'h1234_ABCD) $display("FAIL wr_wdata: got %h exp 1234abcd", iomem_wdata); else n_pass++;
        wait_rsp(cyc);
        n_checks++; if (cyc != 2) $display("FAIL wr_latency: got %0d exp 2", cyc); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rdata: got %h exp 0", rsp_rdata); else n_pass++;
        n_checks++; if (rsp_error !== 1'b0) $display("FAIL wr_error: got %b exp 0", rsp_error); else n_pass++;
        n_checks++; if (iomem_wstrb !== 4'h0) $display("FAIL wr_wstrb_clear: got %b exp 0000", iomem_wstrb); else n_pass++;
        n_checks++; if (gpio_reg[15:0] !== 16'hABCD) $display("FAIL wr_gpio_low: got %h exp abcd", gpio_reg[15:0]); else n_pass++;
        consume();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL wr_done: got %b exp 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        int v0;
        v0 = valid_cycles;
        issue(1'b0, 32'h0500_0000, 32'h0, 4'h0);
        wait_rsp(cyc);
        n_checks++; if (cyc != 8) $display("FAIL to_latency: got %0d exp 8", cyc); else n_pass++;
        n_checks++; if (valid_cycles - v0 != 8) $display("FAIL to_valid_cycles: got %0d exp 8", valid_cycles - v0); else n_pass++;
        n_checks++; if (rsp_error !== 1'b1) $display("FAIL to_error: got %b exp 1", rsp_error); else n_pass++;
        n_checks++; if (rsp_rdata !== ERR) $display("FAIL to_rdata: got %h exp %h", rsp_rdata, ERR); else n_pass++;
        n_checks++; if (iomem_valid !== 1'b0) $display("FAIL to_valid_drop: got %b exp 0", iomem_valid); else n_pass++;
        late_req_cnt++;
        repeat (3) tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== ERR)
            $display("FAIL to_late_ready: got v=%b e=%b d=%h exp 1/1/%h", rsp_valid, rsp_error, rsp_rdata, ERR); else n_pass++;
        consume();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL to_done: got %b exp 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_reject();
        int v0;
        v0 = valid_cycles;
        issue(1'b1, GPIO_ADDR, 32'hFFFF_FFFF, 4'b0000);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rej_rsp_valid: got %b exp 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_error !== 1'b1) $display("FAIL rej_error: got %b exp 1", rsp_error); else n_pass++;
        n_checks++; if (rsp_rdata !== ERR) $display("FAIL rej_rdata: got %h exp %h", rsp_rdata, ERR); else n_pass++;
        n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL rej_busy: got busy=%b cmd_ready=%b exp 1/0", busy, cmd_ready); else n_pass++;
        repeat (2) tick();
        n_checks++; if (valid_cycles != v0) $display("FAIL rej_no_bus: got %0d valid cycles exp 0", valid_cycles - v0); else n_pass++;
        n_checks++; if (gpio_reg !== 32'h0000_ABCD) $display("FAIL rej_gpio: got %h exp 0000abcd", gpio_reg); else n_pass++;
        consume();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rej_done: got %b exp 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(1'b0, 32'h0300_0001, 32'h0, 4'h0);
        wait_rsp(cyc);
        n_checks++; if (rsp_rdata !== 32'h0000_ABCD) $display("FAIL bp_rdata: got %h exp 0000abcd", rsp_rdata); else n_pass++;
        // Offer a second command while the response is stalled.
        cmd_write = 1'b1; cmd_addr = GPIO_ADDR; cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'b0001;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_ABCD || cmd_ready !== 1'b0 || iomem_valid !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%b d=%h cr=%b iv=%b exp 1/0000abcd/0/0",
                         i, rsp_valid, rsp_rdata, cmd_ready, iomem_valid);
            else n_pass++;
        end
        consume();
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b cr=%b exp 0/1", rsp_valid, cmd_ready); else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (iomem_valid !== 1'b1 || iomem_wstrb !== 4'b0001)
            $display("FAIL bp_second_accept: got iv=%b ws=%b exp 1/0001", iomem_valid, iomem_wstrb); else n_pass++;
        wait_rsp(cyc);
        n_checks++; if (rsp_error !== 1'b0 || gpio_reg !== 32'h0000_AB55)
            $display("FAIL bp_second_write: got e=%b gpio=%h exp 0/0000ab55", rsp_error, gpio_reg); else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid();
        int cyc;
        resp_en = 1'b0;
        issue(1'b0, GPIO_ADDR, 32'h0, 4'h0);
        repeat (3) tick();
        n_checks++; if (iomem_valid !== 1'b1) $display("FAIL rm_stalled_valid: got %b exp 1", iomem_valid); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (iomem_valid !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL rm_reset: got iv=%b busy=%b rv=%b cr=%b exp 0/0/0/0", iomem_valid, busy, rsp_valid, cmd_ready);
        else n_pass++;
        reset = 1'b0;
        resp_en = 1'b1;
        tick();
        n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rm_recover: got cr=%b rv=%b exp 1/0", cmd_ready, rsp_valid); else n_pass++;
        issue(1'b0, GPIO_ADDR, 32'h0, 4'h0);
        wait_rsp(cyc);
        n_checks++; if (cyc != 2) $display("FAIL rm_latency: got %0d exp 2", cyc); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0000_AB55 || rsp_error !== 1'b0)
            $display("FAIL rm_read: got d=%h e=%b exp 0000ab55/0", rsp_rdata, rsp_error); else n_pass++;
        consume();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_reject();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iomem_initiator.md
Name: iomem_initiator

Overview:
Bus-master end of the peripheral bus (iomem valid/ready protocol) that our GPIO and template responders answer to. It accepts single read/write commands on a valid/ready command port, runs exactly one iomem transaction per command, and returns read data or error on a valid/ready response port. It lets hardware blocks and the bench drive the mapped peripherals without the CPU. A watchdog ends bus cycles that hang.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles iomem_valid stays high without iomem_ready before abort (legal range 1..65535)
ERR_RDATA, 32'hDEAD_BEEF, rsp_rdata value returned on timeout or on a rejected command

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  32  byte address
cmd_wdata  input  32  write data
cmd_wstrb  input  4  byte enables for writes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when high with rsp_valid
rsp_rdata  output  32  read data (0 for successful writes)
rsp_error  output  1  1 = timeout or rejected command
busy  output  1  high in any state other than IDLE
iomem_valid  output  1  bus request
iomem_ready  input  1  responder completion strobe
iomem_wstrb  output  4  bus byte enables; 4'b0000 means read
iomem_addr  output  32  bus address, word aligned
iomem_wdata  output  32  bus write data
iomem_rdata  input  32  responder read data

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, busy=0, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0. The cycle after reset deasserts, the block enters IDLE with cmd_ready=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, BUS, RESP.
- IDLE: cmd_ready=1. A handshake (cmd_valid && cmd_ready) at edge N moves to BUS, and on the same edge:
  - latches iomem_addr={cmd_addr[31:2],2'b00};
  - latches iomem_wdata=cmd_wdata;
  - latches iomem_wstrb = cmd_write ? cmd_wstrb : 4'b0000;
  - sets iomem_valid=1 and loads the watchdog with TIMEOUT_CYCLES.
  - cmd_ready falls on that same edge.
- Rejected command: if cmd_write=1 and cmd_wstrb=4'b0000 (this would look like a read on the bus), the block goes straight from IDLE to RESP with rsp_error=1 and rsp_rdata=ERR_RDATA. No bus cycle is issued.
- BUS: iomem_valid and iomem_addr/wdata/wstrb are held stable until the cycle ends.
  - Each edge with iomem_ready=0 decrements the watchdog.
  - Edge where iomem_ready=1: clear iomem_valid and iomem_wstrb. Capture rsp_rdata = iomem_rdata for reads, 0 for writes. Set rsp_error=0 and rsp_valid=1, then go to RESP.
  - Edge where the watchdog reaches 0 with iomem_ready=0: clear iomem_valid. Set rsp_rdata=ERR_RDATA, rsp_error=1, rsp_valid=1, then go to RESP.
  - If iomem_ready=1 on the expiry edge, ready wins and the cycle completes normally.
- RESP: rsp_valid, rsp_rdata and rsp_error hold until rsp_ready=1. On that edge rsp_valid drops, cmd_ready rises and the block returns to IDLE. At most one command is outstanding; there is no back-to-back pipelining.
- Latency with a zero-wait responder (ready registered one edge after it sees valid):
  - accept at edge N;
  - iomem_valid high from N;
  - iomem_ready sampled at N+2;
  - rsp_valid high from N+2.
  - Minimum round trip with rsp_ready tied high is 4 cycles per command.
- iomem_ready while iomem_valid=0 (IDLE/RESP, or a late strobe after timeout) is ignored and must not corrupt the response registers.
- Reset mid-transaction: the next edge forces the reset values and drops iomem_valid. The pending command and any response are discarded silently.
- The watchdog is wide enough for 65535. TIMEOUT_CYCLES=1 aborts after exactly one cycle of valid.

Test Plan:
- Read of GPIO responder at 0x0300_0000 returning 0x0000_0003 -> iomem_wstrb=0, iomem_addr=0x0300_0000, rsp_rdata=0x0000_0003, rsp_error=0, rsp_valid 2 edges after accept.
- Write cmd_addr=0x0300_0002, wdata=0x1234_ABCD, wstrb=4'b0011 -> iomem_addr=0x0300_0000, iomem_wstrb=4'b0011, responder register low half=0xABCD, rsp_rdata=0, rsp_error=0.
- Unmapped address 0x0500_0000 (no responder), TIMEOUT_CYCLES=8 -> iomem_valid high exactly 8 cycles, then rsp_error=1, rsp_rdata=0xDEADBEEF; a late iomem_ready pulse afterwards leaves the response unchanged.
- Write with wstrb=4'b0000 -> iomem_valid never asserts, rsp_error=1, rsp_rdata=0xDEADBEEF.
- rsp_ready held low 10 cycles after a read -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; a second cmd_valid is not accepted until the response handshake.
- Assert reset while in BUS with responder stalled -> next edge iomem_valid=0, busy=0, rsp_valid=0; after release a fresh read completes normally.
